decoder_scan_sequencer: RTL and testbench

//  Upstream driver for the 3-to-8 behavioural decoder. Generates en and the select code {A,B,C}.

---
 rtl/decoder_scan_sequencer.sv | 163 ++++++++++++++++
 tb/tb_decoder_scan_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving en and the {A,B,C} select code of a 3-to-8 decoder.
// Walks the set bits of a latched channel mask, holding each channel for
// dwell+1 cycles, in single-pass or continuous wrap-around mode.
module decoder_scan_sequencer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         ch_mask,
    output logic               en,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   sel, sel_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [DWELL_W-1:0] dwell_lat, dwell_lat_nxt;
    logic [NUM_CH-1:0]  mask_lat, mask_lat_nxt;
    logic               mode_lat, mode_lat_nxt;
    logic               en_nxt, busy_nxt, done_nxt, err_nxt;

    logic               higher_found_c;
    logic [SEL_W-1:0]   higher_idx_c;
    logic [SEL_W-1:0]   lowest_lat_c;
    logic [SEL_W-1:0]   lowest_in_c;

    // Index of the lowest set bit (0 when the mask is empty).
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    // Lowest set bit strictly above the current select, if any.
    always_comb begin
        higher_found_c = 1'b0;
        higher_idx_c   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_lat[i] && (i > int'(sel))) begin
                higher_found_c = 1'b1;
                higher_idx_c   = SEL_W'(i);
            end
        end
    end

    assign lowest_lat_c = lowest_set(mask_lat);
    assign lowest_in_c  = lowest_set(ch_mask);

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sel       <= '0;
            cnt       <= '0;
            dwell_lat <= '0;
            mask_lat  <= '0;
            mode_lat  <= 1'b0;
            en        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            cnt       <= cnt_nxt;
            dwell_lat <= dwell_lat_nxt;
            mask_lat  <= mask_lat_nxt;
            mode_lat  <= mode_lat_nxt;
            en        <= en_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel;
        cnt_nxt       = cnt;
        dwell_lat_nxt = dwell_lat;
        mask_lat_nxt  = mask_lat;
        mode_lat_nxt  = mode_lat;
        en_nxt        = en;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                en_nxt   = 1'b0;
                busy_nxt = 1'b0;
                sel_nxt  = '0;
                if (start && !stop) begin
                    if (ch_mask != '0) begin
                        state_nxt     = ST_SCAN;
                        mask_lat_nxt  = ch_mask;
                        dwell_lat_nxt = dwell;
                        mode_lat_nxt  = mode_cont;
                        sel_nxt       = lowest_in_c;
                        cnt_nxt       = '0;
                        en_nxt        = 1'b1;
                        busy_nxt      = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                    sel_nxt   = '0;
                    cnt_nxt   = '0;
                    en_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                end else if (cnt != dwell_lat) begin
                    cnt_nxt = cnt + DWELL_W'(1);
                end else begin
                    cnt_nxt = '0;
                    if (higher_found_c) begin
                        sel_nxt = higher_idx_c;
                    end else if (mode_lat) begin
                        sel_nxt = lowest_lat_c;
                    end else begin
                        state_nxt = ST_IDLE;
                        sel_nxt   = '0;
                        en_nxt    = 1'b0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign A = sel[2];
    assign B = sel[1];
    assign C = sel[0];

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer with an expected-output queue.
module tb_decoder_scan_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode_cont;
    logic [7:0] dwell;
    logic [7:0] ch_mask;
    logic       en, A, B, C, busy, done, err;

    int checks = 0;
    int errors = 0;

    // {en, A, B, C, busy, done, err}
    logic [6:0] exp_q[$];
    string      tag;

    decoder_scan_sequencer #(.DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .mode_cont(mode_cont), .dwell(dwell), .ch_mask(ch_mask),
        .en(en), .A(A), .B(B), .C(C), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic e, input logic [2:0] s, input logic b,
                            input logic d, input logic r);
        exp_q.push_back({e, s, b, d, r});
    endtask

    task automatic push_idle();
        push_exp(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One full single-shot pass: each set channel for dw+1 cycles, then done.
    task automatic push_pass(input logic [7:0] m, input int dw);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                for (int k = 0; k <= dw; k++) push_exp(1'b1, 3'(i), 1'b1, 1'b0, 1'b0);
            end
        end
        push_exp(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    endtask

    // Advance one edge and compare against the oldest expectation.
    task automatic tick();
        logic [6:0] obs, expv;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            obs  = {en, A, B, C, busy, done, err};
            checks++;
            assert (obs === expv) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b (en,ABC,busy,done,err)", tag, obs, expv);
            end
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            tick();
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s queue not drained, %0d left", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
        dwell = 8'd0; ch_mask = 8'd0;

        tag = "reset_state";
        push_idle(); tick();
        push_idle(); tick();
        rst_n = 1'b1;
        push_idle(); tick();

        // Single-shot, all channels, dwell 2
        tag = "single_ff_d2";
        ch_mask = 8'hFF; dwell = 8'd2; mode_cont = 1'b0; start = 1'b1;
        push_pass(8'hFF, 2);
        tick();
        start = 1'b0;
        drain();
        tag = "single_ff_after";
        push_idle(); tick();

        // Single-shot, sparse mask, dwell 0
        tag = "single_a4_d0";
        ch_mask = 8'b1010_0100; dwell = 8'd0; start = 1'b1;
        push_pass(8'b1010_0100, 0);
        tick();
        start = 1'b0;
        drain();

        // Continuous, channels 0 and 7, dwell 1, then stop
        tag = "cont_81_d1";
        ch_mask = 8'h81; dwell = 8'd1; mode_cont = 1'b1; start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            push_exp(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
            push_exp(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
            push_exp(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
            push_exp(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
        end
        tick();
        start = 1'b0;
        drain();
        tag = "cont_stop";
        stop = 1'b1;
        push_idle(); tick();
        stop = 1'b0;
        push_idle(); tick();
        push_idle(); tick();

        // Continuous with a single channel holds the select across wraps
        tag = "cont_single_bit";
        ch_mask = 8'h10; dwell = 8'd0; start = 1'b1;
        for (int k = 0; k < 4; k++) push_exp(1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        drain();
        stop = 1'b1;
        push_idle(); tick();
        stop = 1'b0;

        // Empty mask start is rejected with a one-cycle err
        tag = "err_mask0";
        mode_cont = 1'b0; ch_mask = 8'h00; start = 1'b1;
        push_exp(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        push_idle(); tick();

        // start and input changes during SCAN are ignored
        tag = "scan_ignore_inputs";
        ch_mask = 8'h0C; dwell = 8'd1; start = 1'b1;
        push_pass(8'h0C, 1);
        tick();
        dwell = 8'd5; ch_mask = 8'hFF; mode_cont = 1'b1;
        tick();
        tick();
        start = 1'b0;
        drain();
        push_idle(); tick();

        // start with stop in IDLE does nothing
        tag = "start_and_stop";
        mode_cont = 1'b0; dwell = 8'd0; ch_mask = 8'hFF; start = 1'b1; stop = 1'b1;
        push_idle(); tick();
        push_idle(); tick();
        start = 1'b0; stop = 1'b0;
        push_idle(); tick();

        // Reset mid-scan wins over the scan
        tag = "reset_mid_scan";
        ch_mask = 8'hFF; dwell = 8'd3; start = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        drain();
        rst_n = 1'b0;
        push_idle(); tick();
        push_idle(); tick();
        rst_n = 1'b1;
        push_idle(); tick();
        push_idle(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
